// File: rtl/l1a_smp_pkg.sv
// Shared widths, field positions and helpers for the ring-buffer write-side
// L1A sequencer.
package l1a_smp_pkg;

  localparam int L1ACNT_W  = 24;
  localparam int L1AMCNT_W = 12;
  localparam int OCNT_W    = 4;
  localparam int SMAX_W    = 7;

  // 38-bit sample tag: {phase, match, l1amcnt, l1acnt}
  localparam int TAG_W        = 2 + L1AMCNT_W + L1ACNT_W;
  localparam int TAG_PHASE_B  = TAG_W - 1;
  localparam int TAG_MATCH_B  = TAG_W - 2;
  localparam int TAG_MCNT_LSB = L1ACNT_W;
  localparam int TAG_CNT_LSB  = 0;

  // 6-bit overlap word: {multi_ovlp, ovrlp, ovrlap_cnt}
  localparam int OVR_W       = 2 + OCNT_W;
  localparam int OVR_MULTI_B = OVR_W - 1;
  localparam int OVR_OVRLP_B = OVR_W - 2;
  localparam int OVR_CNT_LSB = 0;

  localparam int MAX_WIN_MIN = 2;
  localparam int MAX_WIN_MAX = (1 << OCNT_W) - 1;

  typedef logic [TAG_W-1:0] l1a_tag_t;
  typedef logic [OVR_W-1:0] ovr_word_t;

  // Number of *other* windows overlapping this sample, saturated to the field.
  function automatic logic [OCNT_W-1:0] ovl_sat(input logic [OCNT_W:0] n);
    logic [OCNT_W:0] m;
    m = (n == '0) ? '0 : n - (OCNT_W+1)'(1);
    return m[OCNT_W] ? '1 : m[OCNT_W-1:0];
  endfunction

endpackage

// File: rtl/smp_win_table.sv
// Table of open readout windows: one remaining-sample down-counter per entry,
// an entry is live while its counter is non-zero.
module smp_win_table
  import l1a_smp_pkg::*;
#(
  parameter int MAX_WIN = 8
) (
  input  logic              CLK,
  input  logic              RST_RESYNC,
  input  logic              alloc_i,
  input  logic [SMAX_W-1:0] alloc_cnt_i,
  input  logic              dec_i,
  output logic              free_o,
  output logic [OCNT_W-1:0] pop_o
);

  logic [MAX_WIN-1:0][SMAX_W-1:0] rem_q, rem_d;
  logic [MAX_WIN-1:0]             vld, sel;

  always_comb begin : p_vld
    logic [OCNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_WIN; i++) begin
      vld[i] = |rem_q[i];
      acc    = acc + {{(OCNT_W-1){1'b0}}, vld[i]};
    end
    pop_o  = acc;
    free_o = ~&vld;
  end

  // Lowest free entry takes the allocation.
  always_comb begin : p_sel
    logic found;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < MAX_WIN; i++) begin
      if (!vld[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  // A freshly loaded entry is decremented by the same advance that opened it,
  // so it stays live for exactly alloc_cnt_i advances including that one.
  always_comb begin
    rem_d = rem_q;
    for (int i = 0; i < MAX_WIN; i++) begin
      if (alloc_i && sel[i]) rem_d[i] = alloc_cnt_i;
      if (dec_i && rem_d[i] != '0) rem_d[i] = rem_d[i] - SMAX_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) rem_q <= '0;
    else            rem_q <= rem_d;
  end

endmodule

// File: rtl/l1a_smp_ctrl.sv
// Write-side sequencer for the DAQ ring buffer: turns L1A pulses into per-sample
// trigger tags, a first-word write strobe and per-sample overlap flags.
module l1a_smp_ctrl
  import l1a_smp_pkg::*;
#(
  parameter int MAX_WIN = 8
) (
  input  logic              CLK,
  input  logic              RST_RESYNC,
  input  logic              L1A,
  input  logic              L1A_MATCH,
  input  logic              SMP_PHASE,
  input  logic              SMP_ADV,
  input  logic [SMAX_W-1:0] SAMP_MAX,
  output logic [TAG_W-1:0]  L1A_SMP_DATA,
  output logic [OVR_W-1:0]  OVRLP_SMP_DATA,
  output logic              L1A_WRT_EN,
  output logic [OCNT_W-1:0] ACTIVE_WIN,
  output logic              L1A_ERR
);

  if (MAX_WIN < MAX_WIN_MIN || MAX_WIN > MAX_WIN_MAX) begin : g_bad_max_win
    $error("l1a_smp_ctrl: MAX_WIN out of range");
  end

  logic [L1ACNT_W-1:0]  cnt_q, cnt_d;
  logic [L1AMCNT_W-1:0] mcnt_q, mcnt_d;
  logic                 pend_q, pend_d;
  l1a_tag_t             ptag_q, ptag_d, tag_q, tag_d;
  ovr_word_t            ovr_q, ovr_d;
  logic                 wrt_q, wrt_d, err_q, err_d;

  logic                 free, drop, issue, alloc;
  logic [OCNT_W-1:0]    pop;
  logic [OCNT_W:0]      nwin;
  logic [SMAX_W-1:0]    load;

  assign load = (SAMP_MAX == '0) ? SMAX_W'(1) : SAMP_MAX;

  always_comb begin
    cnt_d  = cnt_q;
    mcnt_d = mcnt_q;
    pend_d = pend_q;
    ptag_d = ptag_q;
    tag_d  = tag_q;
    ovr_d  = ovr_q;

    drop  = SMP_ADV && pend_q && ptag_q[TAG_MATCH_B] && !free;
    issue = SMP_ADV && pend_q && !drop;
    alloc = issue && ptag_q[TAG_MATCH_B];
    nwin  = {1'b0, pop} + {{OCNT_W{1'b0}}, alloc};

    wrt_d = issue;
    err_d = drop;

    if (issue) tag_d = ptag_q;

    if (SMP_ADV) begin
      pend_d                                = 1'b0;
      ovr_d[OVR_MULTI_B]                    = (nwin >= (OCNT_W+1)'(3));
      ovr_d[OVR_OVRLP_B]                    = (nwin >= (OCNT_W+1)'(2));
      ovr_d[OVR_CNT_LSB +: OCNT_W]          = ovl_sat(nwin);
    end

    // Every L1A is counted; its tag survives only if the pending slot is
    // free this cycle (an advance in the same cycle empties it).
    if (L1A) begin
      cnt_d = cnt_q + L1ACNT_W'(1);
      if (L1A_MATCH) mcnt_d = mcnt_q + L1AMCNT_W'(1);
      if (pend_q && !SMP_ADV) begin
        err_d = 1'b1;
      end else begin
        pend_d                               = 1'b1;
        ptag_d[TAG_PHASE_B]                  = SMP_PHASE;
        ptag_d[TAG_MATCH_B]                  = L1A_MATCH;
        ptag_d[TAG_MCNT_LSB +: L1AMCNT_W]    = mcnt_d;
        ptag_d[TAG_CNT_LSB +: L1ACNT_W]      = cnt_d;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      cnt_q  <= '0;
      mcnt_q <= '0;
      pend_q <= 1'b0;
      ptag_q <= '0;
      tag_q  <= '0;
      ovr_q  <= '0;
      wrt_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mcnt_q <= mcnt_d;
      pend_q <= pend_d;
      ptag_q <= ptag_d;
      tag_q  <= tag_d;
      ovr_q  <= ovr_d;
      wrt_q  <= wrt_d;
      err_q  <= err_d;
    end
  end

  smp_win_table #(.MAX_WIN(MAX_WIN)) u_win_tbl (
    .CLK         (CLK),
    .RST_RESYNC  (RST_RESYNC),
    .alloc_i     (alloc),
    .alloc_cnt_i (load),
    .dec_i       (SMP_ADV),
    .free_o      (free),
    .pop_o       (pop)
  );

  assign L1A_SMP_DATA   = tag_q;
  assign OVRLP_SMP_DATA = ovr_q;
  assign L1A_WRT_EN     = wrt_q;
  assign L1A_ERR        = err_q;
  assign ACTIVE_WIN     = pop;

endmodule

// File: tb/tb_l1a_smp_ctrl.sv
// Bench for l1a_smp_ctrl: constant vector table, directed corner sequences and
// a random run against a queue-based reference model.
module tb_l1a_smp_ctrl;
  import l1a_smp_pkg::*;

  localparam int MW = 8;

  logic        CLK = 1'b0, RST_RESYNC = 1'b1;
  logic        L1A = 1'b0, L1A_MATCH = 1'b0, SMP_PHASE = 1'b0, SMP_ADV = 1'b0;
  logic [6:0]  SAMP_MAX = 7'd8;
  logic [37:0] L1A_SMP_DATA;
  logic [5:0]  OVRLP_SMP_DATA;
  logic        L1A_WRT_EN, L1A_ERR;
  logic [3:0]  ACTIVE_WIN;

  int n_cmp = 0, n_fail = 0;

  l1a_smp_ctrl #(.MAX_WIN(MW)) dut (
    .CLK(CLK), .RST_RESYNC(RST_RESYNC), .L1A(L1A), .L1A_MATCH(L1A_MATCH),
    .SMP_PHASE(SMP_PHASE), .SMP_ADV(SMP_ADV), .SAMP_MAX(SAMP_MAX),
    .L1A_SMP_DATA(L1A_SMP_DATA), .OVRLP_SMP_DATA(OVRLP_SMP_DATA),
    .L1A_WRT_EN(L1A_WRT_EN), .ACTIVE_WIN(ACTIVE_WIN), .L1A_ERR(L1A_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference model: counters as plain integers, windows as a queue of
  // remaining sample counts.
  int unsigned m_cnt, m_mcnt;
  bit          m_pend;
  logic [37:0] m_ptag, e_tag;
  logic [5:0]  e_ovr;
  bit          e_wrt, e_err;
  int          m_win[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_mcnt = 0; m_pend = 0; m_ptag = '0;
    e_tag = '0; e_ovr = '0; e_wrt = 0; e_err = 0;
    m_win.delete();
  endtask

  task automatic model_clk(input bit l1a, input bit match, input bit phase,
                           input bit adv, input int smax);
    int n;
    e_wrt = 0; e_err = 0;
    if (adv) begin
      if (m_pend) begin
        if (m_ptag[36] && m_win.size() >= MW) e_err = 1;
        else begin
          if (m_ptag[36]) m_win.push_back(smax == 0 ? 1 : smax);
          e_wrt = 1;
          e_tag = m_ptag;
        end
      end
      n = m_win.size();
      e_ovr[5]   = (n >= 3);
      e_ovr[4]   = (n >= 2);
      e_ovr[3:0] = 4'((n == 0) ? 0 : ((n - 1 > 15) ? 15 : n - 1));
      for (int k = m_win.size() - 1; k >= 0; k--) begin
        m_win[k] = m_win[k] - 1;
        if (m_win[k] == 0) m_win.delete(k);
      end
      m_pend = 0;
    end
    if (l1a) begin
      m_cnt = (m_cnt + 1) % (1 << 24);
      if (match) m_mcnt = (m_mcnt + 1) % 4096;
      if (m_pend) e_err = 1;
      else begin
        m_pend = 1;
        m_ptag = {phase, match, 12'(m_mcnt), 24'(m_cnt)};
      end
    end
  endtask

  task automatic step(input bit l1a, input bit match, input bit phase, input bit adv);
    L1A = l1a; L1A_MATCH = match; SMP_PHASE = phase; SMP_ADV = adv;
    @(posedge CLK);
    model_clk(l1a, match, phase, adv, int'(SAMP_MAX));
    #1;
    chk("wrt_en",     64'(L1A_WRT_EN),     64'(e_wrt));
    chk("l1a_err",    64'(L1A_ERR),        64'(e_err));
    chk("active_win", 64'(ACTIVE_WIN),     64'(m_win.size()));
    chk("ovrlp_data", 64'(OVRLP_SMP_DATA), 64'(e_ovr));
    chk("smp_data",   64'(L1A_SMP_DATA),   64'(e_tag));
    L1A = 0; L1A_MATCH = 0; SMP_PHASE = 0; SMP_ADV = 0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_smp_data"},   64'(L1A_SMP_DATA),   64'd0);
    chk({pfx, "_ovrlp_data"}, 64'(OVRLP_SMP_DATA), 64'd0);
    chk({pfx, "_wrt_en"},     64'(L1A_WRT_EN),     64'd0);
    chk({pfx, "_active_win"}, 64'(ACTIVE_WIN),     64'd0);
    chk({pfx, "_l1a_err"},    64'(L1A_ERR),        64'd0);
  endtask

  // Reset lands mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    @(posedge CLK); #2 RST_RESYNC = 1'b1; #1;
    chk_zero("rst");
    model_reset();
    @(posedge CLK); #2 RST_RESYNC = 1'b0;
  endtask

  typedef struct {
    bit l1a, match, phase, adv;
    bit wrt, err;
    logic [3:0]  act;
    logic [5:0]  ovr;
    logic [37:0] tag;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(bit l1a, bit match, bit phase, bit adv, bit wrt,
                              bit err, logic [3:0] act, logic [37:0] tag);
    vec_t v;
    v.l1a = l1a; v.match = match; v.phase = phase; v.adv = adv;
    v.wrt = wrt; v.err = err; v.act = act; v.ovr = 6'd0; v.tag = tag;
    return v;
  endfunction

  initial begin
    logic [37:0] t1, t2;
    t1 = {1'b1, 1'b1, 12'd1, 24'd1};
    t2 = {1'b0, 1'b0, 12'd1, 24'd2};
    model_reset();

    // Single matched L1A with SAMP_MAX=8, then an unmatched one.
    vt[0]  = mk(1, 1, 1, 0, 0, 0, 4'd0, 38'd0);
    vt[1]  = mk(0, 0, 0, 1, 1, 0, 4'd1, t1);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 4'd1, t1);
    for (int i = 3; i <= 8; i++) vt[i] = mk(0, 0, 0, 1, 0, 0, 4'd1, t1);
    vt[9]  = mk(0, 0, 0, 1, 0, 0, 4'd0, t1);
    vt[10] = mk(1, 0, 0, 0, 0, 0, 4'd0, t1);
    vt[11] = mk(0, 0, 0, 1, 1, 0, 4'd0, t2);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 4'd0, t2);

    #12;
    chk_zero("init");
    #5 RST_RESYNC = 1'b0;

    SAMP_MAX = 7'd8;
    foreach (vt[i]) begin
      step(vt[i].l1a, vt[i].match, vt[i].phase, vt[i].adv);
      chk("vec_wrt_en",     64'(L1A_WRT_EN),     64'(vt[i].wrt));
      chk("vec_l1a_err",    64'(L1A_ERR),        64'(vt[i].err));
      chk("vec_active_win", 64'(ACTIVE_WIN),     64'(vt[i].act));
      chk("vec_ovrlp_data", 64'(OVRLP_SMP_DATA), 64'(vt[i].ovr));
      chk("vec_smp_data",   64'(L1A_SMP_DATA),   64'(vt[i].tag));
    end

    // Two matched windows three samples apart.
    do_reset();
    SAMP_MAX = 7'd8;
    step(1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    step(0, 0, 0, 1);
    chk("two_win_ovr_s4", 64'(OVRLP_SMP_DATA), 64'h11);
    chk("two_win_mcnt",   64'(L1A_SMP_DATA[35:24]), 64'd2);
    repeat (4) step(0, 0, 0, 1);
    chk("two_win_ovr_s8", 64'(OVRLP_SMP_DATA), 64'h11);
    step(0, 0, 0, 1);
    chk("two_win_ovr_s9", 64'(OVRLP_SMP_DATA), 64'h00);

    // L1A coincident with SMP_ADV, then a lost L1A before the next advance.
    do_reset();
    step(1, 0, 0, 1);
    chk("coinc_no_strobe", 64'(L1A_WRT_EN), 64'd0);
    step(1, 1, 0, 0);
    chk("coinc_lost_err", 64'(L1A_ERR), 64'd1);
    step(0, 0, 0, 1);
    chk("coinc_strobe", 64'(L1A_WRT_EN), 64'd1);
    chk("coinc_cnt1",   64'(L1A_SMP_DATA[23:0]), 64'd1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("coinc_cnt3",   64'(L1A_SMP_DATA[23:0]), 64'd3);

    // Nine matched L1As one sample apart: table overflows on the ninth.
    do_reset();
    SAMP_MAX = 7'd127;
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 0, 0);
      step(0, 0, 0, 1);
    end
    chk("full_err",    64'(L1A_ERR),             64'd1);
    chk("full_no_wrt", 64'(L1A_WRT_EN),          64'd0);
    chk("full_ocnt",   64'(OVRLP_SMP_DATA[3:0]), 64'd7);
    chk("full_active", 64'(ACTIVE_WIN),          64'd8);

    // Reset with three windows open.
    do_reset();
    SAMP_MAX = 7'd20;
    repeat (3) begin
      step(1, 1, 1, 0);
      step(0, 0, 0, 1);
    end
    chk("pre_rst_active", 64'(ACTIVE_WIN), 64'd3);
    do_reset();
    step(1, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("post_rst_cnt",  64'(L1A_SMP_DATA[23:0]),  64'd1);
    chk("post_rst_mcnt", 64'(L1A_SMP_DATA[35:24]), 64'd1);

    // Random traffic, including SAMP_MAX=0 and changes while windows are open.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) SAMP_MAX = 7'($urandom_range(0, 24));
      step($urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/l1a_smp_ctrl.md
Name: l1a_smp_ctrl

Overview:
- Write-side sequencer for the DAQ ring buffer.
- Turns L1A/L1A_MATCH pulses into per-sample trigger tags: event counters, a match flag, L1A phase and a one-word write strobe on the first word of each event window.
- Tracks open readout windows and produces per-sample overlap flags that are stored alongside the ADC data.
- Sits between the trigger-decode logic and the ring buffer write port. Its outputs feed the ring buffer's L1A_SMP_DATA, OVRLP_SMP_DATA and L1A_WRT_EN inputs.

Parameters:
MAX_WIN, 8, maximum number of simultaneously open matched windows (2..15).

Ports:
CLK  in  1  system clock.
RST_RESYNC  in  1  reset, asynchronous, active-high; clock CLK.
L1A  in  1  single-cycle L1A pulse.
L1A_MATCH  in  1  qualifies L1A in the same cycle (matched event).
SMP_PHASE  in  1  sample-clock phase level, captured with L1A.
SMP_ADV  in  1  pulse one CLK before the first write word of every sample.
SAMP_MAX  in  7  samples per event window.
L1A_SMP_DATA  out  38  {phase, match, l1amcnt[11:0], l1acnt[23:0]}.
OVRLP_SMP_DATA  out  6  {multi_ovlp, ovrlp, ovrlap_cnt[3:0]}.
L1A_WRT_EN  out  1  one-cycle strobe on the first word of a window's first sample.
ACTIVE_WIN  out  4  number of currently open matched windows.
L1A_ERR  out  1  one-cycle pulse when an L1A is lost (pending busy or window table full).

Behaviour:
- Reset values: all outputs 0; counters 0; pending flag clear; window table empty.
- L1A counting:
  - Every L1A increments l1acnt (24-bit, wraps at 2^24).
  - Every L1A with L1A_MATCH=1 increments l1amcnt (12-bit, wraps).
  - The tag carries the post-increment values, so the first L1A after reset is event 1.
  - Lost L1As are still counted.
- Pending register (1 deep):
  - L1A captures {SMP_PHASE, L1A_MATCH, l1amcnt, l1acnt} and sets pending.
  - L1A while pending is already set: counted, tag discarded, L1A_ERR pulses, pending contents unchanged.
  - L1A in the same cycle as SMP_ADV: becomes pending for the *next* SMP_ADV, not the current one.
- On each SMP_ADV (cycle T), with the result registered at T+1:
  - a) If pending and match=1 and a free entry exists: allocate a window with remaining = max(SAMP_MAX,1).
  - b) If pending, match=1 and the table is full: no window, no L1A_WRT_EN, L1A_ERR pulses, pending cleared.
  - c) If pending (any match value, excluding case b): L1A_SMP_DATA <= pending tag; L1A_WRT_EN=1 at T+1 only; pending cleared.
  - d) n = number of windows open, including any new one.
    - ovrlap_cnt = min(n-1, 15) when n≥1, else 0.
    - ovrlp = (n≥2); multi_ovlp = (n≥3).
    - OVRLP_SMP_DATA holds these values until the next SMP_ADV.
  - e) Every open window decrements remaining; a window reaching 0 is freed. It covers exactly SAMP_MAX samples, starting at the T+1 sample.
- L1A_SMP_DATA holds its last tag between strobes.
- ACTIVE_WIN reflects the table count after step e (registered).
- SAMP_MAX changes take effect for windows allocated afterwards; open windows keep their loaded count.
- L1A_WRT_EN never asserts except at T+1 after SMP_ADV.
- Reset mid-window: table, pending and counters cleared immediately; no strobe is issued.

Decomposition:
- Package l1a_smp_pkg holds:
  - field widths L1ACNT_W=24, L1AMCNT_W=12, OCNT_W=4;
  - bit-position constants for the 38-bit tag and the 6-bit overlap word;
  - the MAX_WIN range limit.
- One natural sub-module: smp_win_table, holding MAX_WIN down-counters with valid bits, an allocate port, a decrement-on-SMP_ADV port, a free-entry flag and a population count.

Test Plan:
- Single matched L1A, SAMP_MAX=8:
  - L1A_WRT_EN once, tag {x,1,12'd1,24'd1};
  - ovrlp=0 for 8 samples;
  - ACTIVE_WIN returns to 0 after the 8th SMP_ADV.
- Two matched L1As 3 samples apart, SAMP_MAX=8:
  - ovrlp=1 and ovrlap_cnt=1 on samples 4-8 of the first window;
  - multi_ovlp=0 throughout;
  - l1amcnt tags 1, 2.
- Unmatched L1A:
  - L1A_WRT_EN pulses with match=0 and l1acnt incremented;
  - l1amcnt unchanged; no window opens; OVRLP stays 0.
- L1A coincident with SMP_ADV: strobe appears one sample later. A second L1A before the next SMP_ADV pulses L1A_ERR, yet l1acnt still advances to 2.
- MAX_WIN=8 with 9 matched L1As one sample apart, SAMP_MAX=127:
  - 9th gives L1A_ERR and no strobe;
  - ovrlap_cnt saturates at 7;
  - ACTIVE_WIN=8.
- RST_RESYNC asserted with 3 windows open:
  - all outputs 0 asynchronously;
  - the next L1A after release is tagged l1acnt=1.
